// File: rtl/timer_glue.sv
// Glue around the 8253 timer: clock divider, gates, output synchronizers, IRQ0/speaker
// routing and DMA channel 0 refresh requests (refresh built only with TIMER_GLUE_REFRESH_EN).
`timescale 1ns/1ps
module timer_glue #(
   parameter int DIV    = 4,
   parameter int PEND_W = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pit_clk,
   output logic [2:0] pit_gate,
   input  logic [2:0] pit_out,
   input  logic       tmr2_gate,
   input  logic       spkr_data,
   output logic       spkr,
   output logic       irq0,
   output logic       drq0,
   input  logic       dack0_n,
   input  logic       ovf_clr,
   output logic       refresh_ovf
);

   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

   logic [CNT_W-1:0] r_cnt;
   logic             r_pit_clk;
   logic [2:0]       r_sync1;
   logic [2:0]       r_out_s;
   logic             r_spkr;

   // NOTE: all sequential state is written with non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, exactly like the hardware.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_pit_clk <= 1'b0;
         r_sync1   <= '0;
         r_out_s   <= '0;
         r_spkr    <= 1'b0;
      end else begin
         r_cnt     <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
         r_pit_clk <= (r_cnt < CNT_HALF);
         r_sync1   <= pit_out;
         r_out_s   <= r_sync1;
         r_spkr    <= r_out_s[2] & spkr_data;
      end
   end

   assign pit_clk  = r_pit_clk;
   assign pit_gate = {tmr2_gate, 2'b11};
   assign irq0     = r_out_s[0];
   assign spkr     = r_spkr;

`ifdef TIMER_GLUE_REFRESH_EN
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic              r_out1_d;
   logic [PEND_W-1:0] r_pend;
   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_drq0;
   logic              r_ovf;
   logic              w_rise1;
   logic              w_dec;
   logic              w_pend_full;

   assign w_rise1     = r_out_s[1] & ~r_out1_d;
   assign w_dec       = (r_state == ST_REQ) && !dack0_n;
   assign w_pend_full = &r_pend;

   // NOTE: the next state gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (r_pend != '0) w_state_nxt = ST_REQ;
         ST_REQ:  if (!dack0_n)     w_state_nxt = ST_ACK;
         ST_ACK:  if (dack0_n)      w_state_nxt = ST_IDLE;
         default:                   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out1_d <= 1'b0;
         r_pend   <= '0;
         r_state  <= ST_IDLE;
         r_drq0   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_out1_d <= r_out_s[1];
         r_state  <= w_state_nxt;
         r_drq0   <= (w_state_nxt == ST_REQ);
         // A request and a grant in the same cycle cancel; a lost request flags overflow.
         if (w_rise1 && !w_dec) begin
            if (!w_pend_full) r_pend <= r_pend + 1'b1;
         end else if (!w_rise1 && w_dec) begin
            r_pend <= r_pend - 1'b1;
         end
         if (w_rise1 && !w_dec && w_pend_full) r_ovf <= 1'b1;
         else if (ovf_clr)                     r_ovf <= 1'b0;
      end
   end

   assign drq0        = r_drq0;
   assign refresh_ovf = r_ovf;
`else
   logic w_unused;
   assign w_unused    = &{1'b0, dack0_n, ovf_clr, r_out_s[1]};
   assign drq0        = 1'b0;
   assign refresh_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_timer_glue.sv
// Directed bench for timer_glue: divider (DIV=4 and DIV=6), gates, IRQ0, speaker,
// refresh handshake/backlog/overflow and async reset; adapts to TIMER_GLUE_REFRESH_EN.
`timescale 1ns/1ps
module tb_timer_glue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] pit_out;
   logic       tmr2_gate;
   logic       spkr_data;
   logic       dack0_n;
   logic       ovf_clr;

   logic       pit_clk;
   logic [2:0] pit_gate;
   logic       spkr;
   logic       irq0;
   logic       drq0;
   logic       refresh_ovf;

   logic       pit_clk6;
   logic [2:0] pit_gate6;
   logic       spkr6;
   logic       irq06;
   logic       drq06;
   logic       refresh_ovf6;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   timer_glue #(.DIV(4), .PEND_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .pit_clk(pit_clk), .pit_gate(pit_gate),
      .pit_out(pit_out), .tmr2_gate(tmr2_gate), .spkr_data(spkr_data),
      .spkr(spkr), .irq0(irq0), .drq0(drq0), .dack0_n(dack0_n),
      .ovf_clr(ovf_clr), .refresh_ovf(refresh_ovf)
   );

   timer_glue #(.DIV(6), .PEND_W(3)) dut6 (
      .clk(clk), .rst_n(rst_n), .pit_clk(pit_clk6), .pit_gate(pit_gate6),
      .pit_out(pit_out), .tmr2_gate(tmr2_gate), .spkr_data(spkr_data),
      .spkr(spkr6), .irq0(irq06), .drq0(drq06), .dack0_n(dack0_n),
      .ovf_clr(ovf_clr), .refresh_ovf(refresh_ovf6)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic out1_pulse();
      pit_out[1] = 1'b1;
      step(3);
      pit_out[1] = 1'b0;
      step(5);
   endtask

   logic exp4 [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic exp6 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      rst_n     = 1'b0;
      pit_out   = 3'b000;
      tmr2_gate = 1'b0;
      spkr_data = 1'b0;
      dack0_n   = 1'b1;
      ovf_clr   = 1'b0;

      #2;
      check("rst_pit_clk", pit_clk, 0);
      check("rst_irq0", irq0, 0);
      check("rst_spkr", spkr, 0);
      check("rst_drq0", drq0, 0);
      check("rst_ovf", refresh_ovf, 0);
      rst_n = 1'b1;

      // Divider phase from the first edge after reset
      for (int i = 0; i < 8; i++) begin
         step(1);
         check($sformatf("div4_%0d", i), pit_clk, exp4[i]);
         check($sformatf("div6_%0d", i), pit_clk6, exp6[i]);
      end

      // Gates are combinational
      check("gate_off", pit_gate, 3'b011);
      #1 tmr2_gate = 1'b1;
      #1 check("gate_on", pit_gate, 3'b111);
      tmr2_gate = 1'b0;
      #1 check("gate_back", pit_gate, 3'b011);
      step(1);

      // IRQ0: two-edge latency
      pit_out[0] = 1'b1;
      step(1);
      check("irq0_e1", irq0, 0);
      step(1);
      check("irq0_e2", irq0, 1);

      // Speaker: three-edge latency when enabled
      spkr_data  = 1'b1;
      pit_out[2] = 1'b1;
      step(2);
      check("spkr_rise_e2", spkr, 0);
      step(1);
      check("spkr_rise_e3", spkr, 1);
      pit_out[2] = 1'b0;
      step(2);
      check("spkr_fall_e2", spkr, 1);
      step(1);
      check("spkr_fall_e3", spkr, 0);
      spkr_data  = 1'b0;
      pit_out[2] = 1'b1;
      step(4);
      check("spkr_masked", spkr, 0);
      pit_out[2] = 1'b0;

`ifdef TIMER_GLUE_REFRESH_EN
      // Single refresh
      pit_out[1] = 1'b1;
      step(3);
      check("single_pend_e2", dut.r_pend, 1);
      check("single_drq_e2", drq0, 0);
      step(1);
      check("single_drq_e3", drq0, 1);
      pit_out[1] = 1'b0;
      step(2);
      check("single_drq_hold", drq0, 1);
      dack0_n = 1'b0;
      step(1);
      check("single_drq_drop", drq0, 0);
      check("single_pend_0", dut.r_pend, 0);
      dack0_n = 1'b1;
      step(6);
      check("single_no_more", drq0, 0);

      // Backlog of three requests, then three handshakes
      for (int i = 0; i < 3; i++) out1_pulse();
      check("backlog_pend", dut.r_pend, 3);
      check("backlog_drq", drq0, 1);
      for (int i = 0; i < 3; i++) begin
         dack0_n = 1'b0;
         step(1);
         check($sformatf("hs%0d_drop", i), drq0, 0);
         check($sformatf("hs%0d_pend", i), dut.r_pend, 2 - i);
         dack0_n = 1'b1;
         step(1);
         check($sformatf("hs%0d_e1", i), drq0, 0);
         step(1);
         check($sformatf("hs%0d_e2", i), drq0, (i < 2) ? 1 : 0);
      end
      step(4);
      check("backlog_end_pend", dut.r_pend, 0);
      check("backlog_end_drq", drq0, 0);

      // Overflow at saturation
      for (int i = 0; i < 7; i++) out1_pulse();
      check("ovf_pend7", dut.r_pend, 7);
      check("ovf_not_yet", refresh_ovf, 0);
      out1_pulse();
      check("ovf_pend_sat", dut.r_pend, 7);
      check("ovf_set", refresh_ovf, 1);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("ovf_cleared", refresh_ovf, 0);
      pit_out[1] = 1'b1;
      step(2);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("ovf_set_wins", refresh_ovf, 1);
      pit_out[1] = 1'b0;
      step(3);
      check("ovf_pre_rst_drq", drq0, 1);
`else
      // Refresh logic absent: OUT1 and the handshake inputs have no effect
      for (int i = 0; i < 9; i++) out1_pulse();
      check("off_drq", drq0, 0);
      check("off_ovf", refresh_ovf, 0);
      dack0_n = 1'b0;
      ovf_clr = 1'b1;
      step(2);
      check("off_drq_dack", drq0, 0);
      dack0_n = 1'b1;
      ovf_clr = 1'b0;
`endif

      // Asynchronous reset mid-cycle
      check("pre_rst_irq0", irq0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_drq0", drq0, 0);
      check("arst_ovf", refresh_ovf, 0);
      check("arst_irq0", irq0, 0);
      check("arst_spkr", spkr, 0);
      check("arst_pit_clk", pit_clk, 0);
      pit_out = 3'b000;
      step(1);
      rst_n = 1'b1;
      step(4);
      check("post_rst_drq0", drq0, 0);
      check("post_rst_ovf", refresh_ovf, 0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
